// File: rtl/rwstack_pkg.sv
// Shared op encodings for the read/write stack command front-end.
package rwstack_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_PEEK  = 2'b00,
        OP_PUSH  = 2'b01,
        OP_POP   = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

endpackage

// File: rtl/rwstack_cmd_if_if.sv
// Command and response valid/ready streams of the stack front-end.
interface rwstack_cmd_if_if
    import rwstack_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);

    logic            i_cmd_valid;
    logic            o_cmd_ready;
    logic [OP_W-1:0] i_cmd_op;
    logic [WIDTH-1:0] i_cmd_data;
    logic            o_rsp_valid;
    logic            i_rsp_ready;
    logic [WIDTH-1:0] o_rsp_data;
    logic            o_rsp_err;

    modport slave (
        input  i_cmd_valid, i_cmd_op, i_cmd_data, i_rsp_ready,
        output o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_err
    );

    modport master (
        output i_cmd_valid, i_cmd_op, i_cmd_data, i_rsp_ready,
        input  o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_err
    );

endinterface

// File: rtl/rwstack_rsp_slot.sv
// One-entry response register; a new load overwrites the entry even while it drains.
module rwstack_rsp_slot #(
    parameter int unsigned W = 33
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            if (i_load) begin
                o_valid <= 1'b1;
                o_data  <= i_data;
            end else if (i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rwstack_cmd_if.sv
// Stack command front-end: turns PEEK/PUSH/POP/CLEAR commands into stack strobes and responses.
// Define RWSTACK_CMD_ERR_RSP_EN to return error responses for full/empty misuse.
module rwstack_cmd_if
    import rwstack_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTHBITS = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    rwstack_cmd_if_if.slave      cmd_bus,
    output logic                 o_stk_enable,
    output logic                 o_stk_push,
    output logic                 o_stk_pop,
    output logic                 o_stk_sreset,
    output logic [WIDTH-1:0]     o_stk_din,
    input  logic [WIDTH-1:0]     i_stk_top,
    input  logic                 i_stk_empty,
    input  logic                 i_stk_full,
    output logic [DEPTHBITS:0]   o_count
);

    localparam int unsigned CNT_W = DEPTHBITS + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << DEPTHBITS) + 1);

`ifdef RWSTACK_CMD_ERR_RSP_EN
    localparam bit ERR_RSP_EN = 1'b1;
`else
    localparam bit ERR_RSP_EN = 1'b0;
`endif

    logic             is_peek, is_push, is_pop, is_clear, is_rd;
    logic             slot_free, push_err, cmd_ready, fire, stack_op, rsp_load;
    logic             settle;
    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   rsp_din;
    logic [WIDTH:0]   rsp_q;
    logic             rsp_valid;

    // Acceptance: reads wait out the RAM latency and need a free slot.
    always_comb begin
        is_peek   = (cmd_bus.i_cmd_op == OP_PEEK);
        is_push   = (cmd_bus.i_cmd_op == OP_PUSH);
        is_pop    = (cmd_bus.i_cmd_op == OP_POP);
        is_clear  = (cmd_bus.i_cmd_op == OP_CLEAR);
        is_rd     = is_peek | is_pop;
        slot_free = ~rsp_valid | cmd_bus.i_rsp_ready;
        push_err  = ERR_RSP_EN & is_push & i_stk_full;
        cmd_ready = 1'b1;
        if (i_reset) begin
            cmd_ready = 1'b0;
        end else if (is_rd) begin
            cmd_ready = ~settle & slot_free;
        end else if (push_err) begin
            cmd_ready = slot_free;
        end
        fire = cmd_bus.i_cmd_valid & cmd_ready;
    end

    assign o_stk_enable = fire;
    assign o_stk_push   = fire & is_push & ~i_stk_full;
    assign o_stk_pop    = fire & is_pop & ~i_stk_empty;
    assign o_stk_sreset = fire & is_clear;
    assign o_stk_din    = cmd_bus.i_cmd_data;
    assign stack_op     = o_stk_push | o_stk_pop | o_stk_sreset;
    assign rsp_load     = fire & (is_rd | push_err);

    // Response payload is {err, data}; an empty stack reads as zero.
    always_comb begin
        rsp_din = {1'b0, i_stk_top};
        if (push_err) begin
            rsp_din = {1'b1, cmd_bus.i_cmd_data};
        end else if (i_stk_empty) begin
            rsp_din = {1'(ERR_RSP_EN), WIDTH'(0)};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            settle <= 1'b0;
            count  <= '0;
        end else begin
            settle <= stack_op;
            if (o_stk_sreset) begin
                count <= '0;
            end else if (o_stk_push && (count != CNT_MAX)) begin
                count <= count + CNT_W'(1);
            end else if (o_stk_pop && (count != '0)) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    rwstack_rsp_slot #(
        .W (WIDTH + 1)
    ) u_rsp_slot (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (rsp_load),
        .i_data  (rsp_din),
        .i_ready (cmd_bus.i_rsp_ready),
        .o_valid (rsp_valid),
        .o_data  (rsp_q)
    );

    assign cmd_bus.o_cmd_ready = cmd_ready;
    assign cmd_bus.o_rsp_valid = rsp_valid;
    assign cmd_bus.o_rsp_data  = rsp_q[WIDTH-1:0];
    assign cmd_bus.o_rsp_err   = rsp_q[WIDTH];
    assign o_count             = count;

endmodule

// File: doc/rwstack_cmd_if.md
# rwstack_cmd_if

Command front-end that sits directly upstream of the on-chip read/write stack in the MMM datapath. It accepts a valid/ready stream of PEEK/PUSH/POP/CLEAR commands, converts each into the stack's single-cycle push/pop/sreset/enable strobes, and returns PEEK/POP results on a valid/ready response stream. It also enforces the stack's one-cycle RAM read latency and guards against full/empty misuse.

## Interface
- WIDTH, 32, data width; must equal the stack's WIDTH.
- DEPTHBITS, 8, stack RAM address bits; the stack holds up to 2**DEPTHBITS+1 entries, top register included.
- i_clk  in  1  sole clock.
- i_reset  in  1  reset; synchronous, active-high.
- i_cmd_valid  in  1  command present.
- o_cmd_ready  out  1  command accepted when valid and ready are both high ("fire").
- i_cmd_op  in  2  00 PEEK, 01 PUSH, 10 POP, 11 CLEAR.
- i_cmd_data  in  WIDTH  push value; ignored for other ops.
- o_rsp_valid  out  1  response present.
- i_rsp_ready  in  1  response consumed.
- o_rsp_data  out  WIDTH  PEEK/POP value.
- o_rsp_err  out  1  error flag; see Configuration.
- o_stk_enable, o_stk_push, o_stk_pop, o_stk_sreset  out  1 each  strobes to the stack.
- o_stk_din  out  WIDTH  push data to the stack, equal to i_cmd_data.
- i_stk_top  in  WIDTH  stack top.
- i_stk_empty, i_stk_full  in  1 each  stack status.
- o_count  out  DEPTHBITS+1  current entry count.

## Operation
- Stack strobes are combinational from the fire condition:
  - o_stk_enable = fire.
  - o_stk_push = fire & PUSH & !i_stk_full.
  - o_stk_pop = fire & POP & !i_stk_empty.
  - o_stk_sreset = fire & CLEAR.
- A "stack op" is a legal PUSH or POP, or any CLEAR. A PEEK or an illegal op is not a stack op.
- Settle rule: a PEEK or POP is not accepted in the cycle immediately after a stack op, because the RAM read has a one-cycle latency. A 1-bit settle register is set on a stack op and cleared otherwise.
  - o_cmd_ready is low when settle=1 and i_cmd_op is PEEK or POP.
  - PUSH and CLEAR are never blocked by settle.
- Response slot: one entry. A PEEK or POP is accepted only when the slot is empty, or is being drained in the same cycle (o_rsp_valid & i_rsp_ready).
- PEEK and POP capture i_stk_top in the fire cycle. POP and PEEK on an empty stack: captured data is 0.
- o_count:
  - +1 on a legal PUSH, −1 on a legal POP.
  - Cleared to 0 on CLEAR.
  - Saturates at 2**DEPTHBITS+1.
- Simultaneous drain and new PEEK/POP fire: the slot is overwritten with the new value, and o_rsp_valid stays high.

## Timing
- Reset (one cycle of i_reset high) sets:
  - o_cmd_ready=0, o_rsp_valid=0, o_rsp_data=0, o_rsp_err=0, o_count=0, settle=0.
  - All stack strobes 0.
  - o_cmd_ready rises in the first cycle after reset deasserts.
- Reset in mid-operation discards any pending response. The stack is not cleared by this reset; issue CLEAR for that.
- PEEK/POP latency: fire in cycle N gives o_rsp_valid in cycle N+1. The response is held stable until i_rsp_ready.
- Throughput:
  - PUSH: one per cycle.
  - POP→POP and PUSH→POP: one every 2 cycles.
  - PEEK→PEEK: one per cycle.

## Configuration
- RWSTACK_CMD_ERR_RSP_EN defined:
  - PUSH on full is consumed, no stack strobe, and produces a response with err=1 and data = the rejected i_cmd_data.
  - PEEK/POP on empty produces a response with err=1 and data 0.
  - A PUSH that returns an error response needs the response slot free to be accepted.
- Not defined:
  - PUSH on full is dropped silently with no response.
  - PEEK/POP on empty responds with data 0 and err=0.
  - o_rsp_err is tied 0.

## Structure
- rwstack_pkg holds:
  - op encodings OP_PEEK, OP_PUSH, OP_POP, OP_CLEAR.
  - op width constant OP_W=2.
- One sub-module, rwstack_rsp_slot: the 1-entry response register with valid/ready and overwrite-on-drain, parameterised by WIDTH+1 (data plus err).
- Top level holds: fire/ready logic, settle register, count, strobe generation.

## Test plan
- Reset, then PUSH 0xA, 0xB, 0xC on consecutive cycles → three fires in three cycles; o_count=3; o_stk_push high in each.
- Next cycle POP, then POP with i_rsp_ready=1 → first POP blocked 1 cycle by settle; responses 0xC, then 0xB; second POP accepted 2 cycles after the first; o_count=1.
- PEEK ×2 back-to-back → both return 0xA; o_count unchanged.
- POP on empty with the macro on → rsp err=1, data 0. Same with the macro off → err=0, data 0; no o_stk_pop either way.
- Fill to 2**DEPTHBITS+1 entries, PUSH 0x55 → no o_stk_push; with the macro on, response err=1 data 0x55; with it off, no response. o_count saturated.
- Hold i_rsp_ready=0 with a response pending, issue POP → o_cmd_ready=0 until drained. Then CLEAR → o_stk_sreset one cycle, o_count=0. Assert i_reset mid-response → o_rsp_valid=0 the next cycle.
